// File: rtl/qe_pkg.sv
// Shared definitions for the QE_M operand feeder.
//   MODE_BIT / LAST_BIT     : header byte bit positions
//   DEFAULT_FIFO_DEPTH      : default assembled-operation buffer depth
//   asm_state_t             : byte assembler states
//   qe_op_t                 : one assembled operation {mode,last,a,b,c,x}
//   hdr_reserved_clear()    : true when header reserved bits 7:2 are all zero
package qe_pkg;

  localparam int MODE_BIT           = 0;
  localparam int LAST_BIT           = 1;
  localparam int DEFAULT_FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    ST_HDR = 3'd0,
    ST_A   = 3'd1,
    ST_B   = 3'd2,
    ST_C   = 3'd3,
    ST_X   = 3'd4
  } asm_state_t;

  typedef struct packed {
    logic       mode;
    logic       last;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] x;
  } qe_op_t;

  function automatic logic hdr_reserved_clear(input logic [7:0] hdr);
    return (hdr[7:2] == 6'd0);
  endfunction

endpackage

// File: rtl/qe_op_fifo.sv
// Synchronous buffer of assembled operations.
//   clk, reset (sync, active-low)
//   push, push_op : write one operation (ignored when full)
//   pop, pop_op   : pop_op shows the head; pop advances it (ignored when empty)
//   full, empty   : flags decoded from the registered occupancy count
module qe_op_fifo
  import qe_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  qe_op_t push_op,
  input  logic   pop,
  output qe_op_t pop_op,
  output logic   full,
  output logic   empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  qe_op_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_en;
  logic          pop_en;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;
  assign pop_op  = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= push_op;
  end

endmodule

// File: rtl/qe_m_feeder.sv
// Byte-stream to QE_M operation feeder.
//   clk, reset (sync, active-low)
//   s_data/s_valid/s_ready : input byte stream, header then operand bytes
//   in_a, in_b, in_c, in_x : registered operands to QE_M
//   mode, last_input       : registered controls to QE_M
//   valid_in               : one-cycle pulse per delivered operation
//   err_hdr, err_seq       : sticky error flags, cleared only by reset
module qe_m_feeder
  import qe_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [7:0] in_a,
  output logic [7:0] in_b,
  output logic [7:0] in_c,
  output logic [7:0] in_x,
  output logic       mode,
  output logic       valid_in,
  output logic       last_input,
  output logic       err_hdr,
  output logic       err_seq
);

  asm_state_t state;
  asm_state_t state_nxt;
  logic       accept;
  logic       hdr_ok;
  logic       hdr_mode;
  logic       push;
  qe_op_t     push_op;
  qe_op_t     head_op;
  logic       fifo_full;
  logic       fifo_empty;
  logic       mode_p0;
  logic       last_p0;
  logic       drop_p0;
  logic       seq_open;
  logic [7:0] a_p0;
  logic [7:0] b_p0;
  logic [7:0] c_p0;
  logic       vld_p1;
  qe_op_t     op_p1;

  // Gated by reset so no byte is taken while reset is held.
  assign s_ready  = reset & ~fifo_full;
  assign accept   = s_valid & s_ready;
  assign hdr_ok   = hdr_reserved_clear(s_data);
  assign hdr_mode = s_data[MODE_BIT];

  // Stage p0: byte assembler
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_HDR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_op   = '{mode: mode_p0, last: last_p0, a: a_p0, b: b_p0, c: c_p0, x: s_data};
    case (state)
      ST_HDR: if (accept && hdr_ok) state_nxt = ST_A;
      ST_A:   if (accept) state_nxt = mode_p0 ? ST_X : ST_B;
      ST_B:   if (accept) state_nxt = ST_C;
      ST_C:   if (accept) state_nxt = ST_X;
      ST_X: begin
        if (accept) begin
          state_nxt = ST_HDR;
          // A dropped frame still walks A..X so its payload is consumed.
          push      = ~drop_p0;
        end
      end
      default: state_nxt = ST_HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_p0  <= 1'b0;
      last_p0  <= 1'b0;
      drop_p0  <= 1'b0;
      seq_open <= 1'b0;
      err_hdr  <= 1'b0;
      err_seq  <= 1'b0;
    end else begin
      if (state == ST_HDR && accept) begin
        if (!hdr_ok) begin
          err_hdr <= 1'b1;
        end else begin
          mode_p0 <= hdr_mode;
          // last only has meaning inside a MAC sequence.
          last_p0 <= hdr_mode & s_data[LAST_BIT];
          drop_p0 <= ~hdr_mode & seq_open;
          if (~hdr_mode & seq_open) err_seq <= 1'b1;
        end
      end
      if (push && mode_p0) seq_open <= ~last_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      case (state)
        ST_HDR: begin
          if (hdr_ok) begin
            b_p0 <= 8'd0;
            c_p0 <= 8'd0;
          end
        end
        ST_A:    a_p0 <= s_data;
        ST_B:    b_p0 <= s_data;
        ST_C:    c_p0 <= s_data;
        default: ;
      endcase
    end
  end

  qe_op_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .push_op (push_op),
    .pop     (~fifo_empty),
    .pop_op  (head_op),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Stage p1: output register, pops the head every cycle it exists
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_p1 <= 1'b0;
      op_p1  <= '0;
    end else if (!fifo_empty) begin
      vld_p1 <= 1'b1;
      op_p1  <= head_op;
    end else begin
      vld_p1 <= 1'b0;
    end
  end

  assign valid_in   = vld_p1;
  assign mode       = op_p1.mode;
  assign last_input = op_p1.last;
  assign in_a       = op_p1.a;
  assign in_b       = op_p1.b;
  assign in_c       = op_p1.c;
  assign in_x       = op_p1.x;

endmodule

// File: doc/qe_m_feeder.md
QE_M_FEEDER -- requirements
Module: qe_m_feeder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning assembled-operation buffer depth (power of two, >=2).
REQ-002 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port s_data  input  8  byte stream (header or operand byte).
REQ-005 SHALL have port s_valid  input  1  s_data valid.
REQ-006 SHALL have port s_ready  output  1  byte accepted when s_valid && s_ready at a rising edge.
REQ-007 SHALL have ports in_a, in_b, in_c, in_x  output  8 each  operands to QE_M.
REQ-008 SHALL have ports mode, valid_in, last_input  output  1 each  controls to QE_M.
REQ-009 SHALL have port err_hdr  output  1  sticky: a header with reserved bits nonzero was dropped.
REQ-010 SHALL have port err_seq  output  1  sticky: a mode-0 header arrived while a MAC sequence was open.

Function
REQ-011 Header byte: bit0 = mode (0 quadratic, 1 MAC), bit1 = last, bits7:2 reserved (must be 0).
REQ-012 Frame after header: mode 0 -> a, b, c, x (4 bytes); mode 1 -> a, x (2 bytes); b and c SHALL be stored as 0 for mode 1.
REQ-013 Assembler FSM states: HDR, A, B, C, X; HDR->A on valid header; A->B (mode 0) or A->X (mode 1); B->C; C->X; X->HDR on x byte accepted.
REQ-014 A header with reserved bits nonzero SHALL be consumed, set err_hdr, and keep the FSM in HDR.
REQ-015 A mode-0 header while seq_open=1 SHALL set err_seq, be consumed, and be dropped with its 4 payload bytes (FSM walks A..X, no FIFO push).
REQ-016 seq_open SHALL set when a mode-1, last=0 operation is pushed and clear when a mode-1, last=1 operation is pushed; last bit on mode-0 headers SHALL be ignored and driven last_input=0.
REQ-017 On x byte acceptance the operation {mode,last,a,b,c,x} SHALL be pushed into the FIFO in the same edge.
REQ-018 s_ready SHALL equal (FIFO count < FIFO_DEPTH); header and operand bytes are both stalled when full.
REQ-019 Outputs SHALL be registered: each cycle with FIFO non-empty, head pops and outputs load it with valid_in=1; when empty, valid_in=0 and operand/mode/last_input hold their previous values.
REQ-020 Latency: x byte accepted at edge k with FIFO empty -> valid_in=1 in the cycle after edge k+1; throughput one operation per cycle.
REQ-021 Simultaneous push and pop SHALL leave count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-022 valid_in SHALL be a single-cycle pulse per operation; no operation duplicated or lost.
REQ-023 err_hdr/err_seq SHALL clear only on reset.

Reset
REQ-024 While reset=0 at an edge: FSM->HDR, FIFO empty, seq_open=0, s_ready=0 during reset then 1 after.
REQ-025 Reset values: valid_in=0, mode=0, last_input=0, in_a=in_b=in_c=in_x=0, err_hdr=0, err_seq=0.
REQ-026 Reset mid-frame SHALL discard the partial frame and all buffered operations; first byte after reset is a header.

Structure
REQ-027 Shared package qe_pkg SHALL hold header bit positions (MODE_BIT=0, LAST_BIT=1), FSM state enum, operation record type, default FIFO depth.
REQ-028 Buffer SHALL be a sub-module qe_op_fifo (synchronous, registered count, full/empty flags); assembler FSM and output register stay in qe_m_feeder.

Verification
REQ-029 Bytes 0x00,100,5,25,8 back-to-back -> one valid_in pulse, mode=0, a=100,b=5,c=25,x=8, last_input=0, 2 cycles after x byte.
REQ-030 Bytes 0x01,100,8 then 0x03,1,2 -> two pulses: (mode=1,a=100,x=8,b=c=0,last=0) then (mode=1,a=1,x=2,last=1); seq_open 1 then 0.
REQ-031 Hold valid_in path: push 5 mode-0 frames with no gaps, FIFO_DEPTH=4 -> s_ready never blocks (pop each cycle), 5 pulses in order, none lost.
REQ-032 Header 0x04 -> err_hdr=1, no pulse; following 0x00,4,7,11,1 -> normal pulse a=4,b=7,c=11,x=1.
REQ-033 0x01,20,3 then 0x00,100,5,3,0 -> err_seq=1, only the MAC pulse emitted; 0x03,1,2 then closes sequence normally.
REQ-034 reset=0 asserted after bytes 0x00,100,5 -> all outputs return to reset values, no pulse; next frame 0x00,100,5,3,0 produces a=100,b=5,c=3,x=0.
